uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- UART receiver that pairs with the team's UART transmitter in the debug UART interface.
- Deserialises an 8N1 frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Samples each bit at its centre using a CLK_RATE/BAUD_RATE down-counter.
- Presents the received byte with a one-cycle done strobe, or a one-cycle framing-error strobe, to the downstream debug frame logic.

Parameters:
- CLK_RATE, 100*10**6, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- Derived, not overridable: SAMPLE_INTERVAL = CLK_RATE/BAUD_RATE (integer division); HALF_INTERVAL = SAMPLE_INTERVAL/2.
- Elaboration-time check: SAMPLE_INTERVAL >= 4, else fatal.

Ports:
- CLK_I  input  1  system clock, all logic on rising edge.
- RST_I  input  1  asynchronous, active-high reset.
- RX_I  input  1  serial line, asynchronous to CLK_I, idle high.
- DATA_O  output  8  last correctly received byte.
- RX_DONE_O  output  1  one-cycle strobe; DATA_O valid from this cycle.
- FRAME_ERR_O  output  1  one-cycle strobe; stop bit sampled as 0.
- BUSY_O  output  1  high while in any state other than ST_IDLE.

Behaviour:
- Reset: asynchronous and active-high.
  - Reset values: DATA_O=0, RX_DONE_O=0, FRAME_ERR_O=0, BUSY_O=0, state=ST_IDLE.
  - Both synchroniser flops reset to 1, bit counter to 0, baud counter to 0.
  - Reset mid-frame aborts with no strobe; the partial byte is discarded and DATA_O returns to 0.
- Synchroniser: two-flop synchroniser on RX_I giving rx_s. All decisions use rx_s only, so there are 2 cycles of input latency.
- Baud counter:
  - Width $clog2(SAMPLE_INTERVAL).
  - Loaded on state entry, decremented every cycle.
  - Issues a "sample" event in the cycle it reads 0.
  - On a sample event it reloads with SAMPLE_INTERVAL-1, except on the final stop-bit sample.
- States:
  - ST_IDLE:
    - If rx_s==0: load the counter with HALF_INTERVAL-1, go to ST_START.
  - ST_START (at the sample event):
    - rx_s==1: glitch; go to ST_IDLE with no strobe.
    - rx_s==0: bit counter=0, go to ST_DATA.
  - ST_DATA (at each sample event):
    - Shift rx_s into the MSB of the shift register, shifting right, so the LSB is received first.
    - Bit counter +1.
    - After the 8th sample, go to ST_STOP.
  - ST_STOP (at the sample event):
    - rx_s==1: DATA_O<=shift register, RX_DONE_O=1 for 1 cycle, go to ST_IDLE.
    - rx_s==0: FRAME_ERR_O=1 for 1 cycle, DATA_O unchanged, go to ST_WAIT_HIGH.
  - ST_WAIT_HIGH:
    - Remain until rx_s==1, then go to ST_IDLE.
    - This stops a held-low line (break) from being read as repeated 0x00 frames.
- Strobes are registered outputs.
  - RX_DONE_O and FRAME_ERR_O are never high together.
  - Neither is asserted for two consecutive cycles.
- Back-to-back frames:
  - Returning to ST_IDLE at the stop-bit centre means a start bit immediately following the stop bit is detected with no gap.
  - No minimum idle time is required between frames.
- DATA_O holds its value until the next successful frame. It does not change on a framing error or a glitch.
- Latency:
  - Measured from the RX_I falling edge of the start bit to RX_DONE_O.
  - Nominal value is 2 + HALF_INTERVAL + 9*SAMPLE_INTERVAL + 1 cycles, ±1.
  - BUSY_O rises 3 cycles after the start edge.
- Baud tolerance: correct reception for a line rate within ±3% of BAUD_RATE.

Test Plan:
- CLK_RATE=1_000_000, BAUD_RATE=100_000 (interval 10): send 0xA5 after reset -> RX_DONE_O pulse of 1 cycle, 98±1 cycles after start edge, DATA_O=0xA5, FRAME_ERR_O never high.
- Two frames 0x00 then 0xFF back-to-back with no idle -> two RX_DONE_O pulses 100±1 cycles apart, DATA_O=0x00 then 0xFF.
- Low glitch of 3 cycles on an idle line -> no strobe, BUSY_O returns to 0 within 10 cycles, DATA_O unchanged.
- Frame 0x3C with stop bit forced 0, then line held low for 50 cycles, then high, then valid frame 0x12:
  - FRAME_ERR_O pulses once; DATA_O stays at its previous value; no strobe while the line is held low.
  - The following frame yields DATA_O=0x12.
- RST_I asserted at bit 4 of frame 0x55 -> outputs cleared immediately (asynchronously), no strobe. The next full frame 0x81 is received correctly.
- Line rate 3% fast and 3% slow with frame 0xC3 -> DATA_O=0xC3, RX_DONE_O pulse in both cases.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, centre sampling, framing check.
// Ports: CLK_I, RST_I (async high), RX_I -> DATA_O, RX_DONE_O, FRAME_ERR_O, BUSY_O.
module uart_rx_core #(
  parameter int CLK_RATE  = 100*10**6,
  parameter int BAUD_RATE = 115200
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       RX_I,
  output logic [7:0] DATA_O,
  output logic       RX_DONE_O,
  output logic       FRAME_ERR_O,
  output logic       BUSY_O
);

  localparam int SAMPLE_INTERVAL = CLK_RATE / BAUD_RATE;
  localparam int HALF_INTERVAL   = SAMPLE_INTERVAL / 2;
  localparam int CW              = $clog2(SAMPLE_INTERVAL);

  localparam logic [CW-1:0] FULL_LOAD = CW'(SAMPLE_INTERVAL - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_INTERVAL - 1);

  if (SAMPLE_INTERVAL < 4) begin : g_rate_chk
    $fatal(1, "uart_rx_core: CLK_RATE/BAUD_RATE must be >= 4");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t          state;
  logic            rx_m;
  logic            rx_s;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            sample;

  assign sample = (baud_cnt == '0);
  assign BUSY_O = (state != ST_IDLE);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      state       <= ST_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      DATA_O      <= '0;
      RX_DONE_O   <= 1'b0;
      FRAME_ERR_O <= 1'b0;
    end else begin
      rx_m        <= RX_I;
      rx_s        <= rx_m;
      RX_DONE_O   <= 1'b0;
      FRAME_ERR_O <= 1'b0;
      baud_cnt    <= sample ? FULL_LOAD : baud_cnt - 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            baud_cnt <= HALF_LOAD;
            state    <= ST_START;
          end
        end
        ST_START: begin
          if (sample) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              bit_cnt <= '0;
              state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (sample) begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sample) begin
            // Idle from the stop-bit centre so an abutting start bit is caught.
            baud_cnt <= baud_cnt - 1'b1;
            if (rx_s) begin
              DATA_O    <= shift;
              RX_DONE_O <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              FRAME_ERR_O <= 1'b1;
              state       <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          // A held-low line (break) must not decode as repeated 0x00 frames.
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed testbench for uart_rx_core at 1 MHz clock, 100 kbaud.
// Bit time is 10 clocks; frames are driven with real-time delays.
`timescale 1ns/1ps
module tb_uart_rx_core;

  logic       CLK_I;
  logic       RST_I;
  logic       RX_I;
  logic [7:0] DATA_O;
  logic       RX_DONE_O;
  logic       FRAME_ERR_O;
  logic       BUSY_O;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_n = 0;
  int err_n = 0;
  int viol = 0;
  int done_cyc[$];
  logic [7:0] done_data[$];
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;

  uart_rx_core #(
    .CLK_RATE (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .RX_I       (RX_I),
    .DATA_O     (DATA_O),
    .RX_DONE_O  (RX_DONE_O),
    .FRAME_ERR_O(FRAME_ERR_O),
    .BUSY_O     (BUSY_O)
  );

  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  always @(posedge CLK_I) cyc <= cyc + 1;

  always @(negedge CLK_I) begin
    if (RX_DONE_O) begin
      done_n++;
      done_cyc.push_back(cyc);
      done_data.push_back(DATA_O);
    end
    if (FRAME_ERR_O) err_n++;
    if (RX_DONE_O && FRAME_ERR_O) viol++;
    if (RX_DONE_O && prev_done) viol++;
    if (FRAME_ERR_O && prev_err) viol++;
    prev_done = RX_DONE_O;
    prev_err  = FRAME_ERR_O;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input realtime bt);
    RX_I = 1'b0;
    #bt;
    for (int i = 0; i < 8; i++) begin
      RX_I = d[i];
      #bt;
    end
    RX_I = stop;
    #bt;
  endtask

  task automatic align();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic test_reset();
    RST_I = 1'b1;
    RX_I  = 1'b1;
    repeat (3) @(posedge CLK_I);
    #1;
    checks++;
    if ({DATA_O, RX_DONE_O, FRAME_ERR_O, BUSY_O} !== 11'h000) begin
      errors++;
      $display("FAIL reset_values: got %h/%b/%b/%b want 00/0/0/0",
               DATA_O, RX_DONE_O, FRAME_ERR_O, BUSY_O);
    end
    RST_I = 1'b0;
    repeat (20) @(posedge CLK_I);
  endtask

  task automatic test_single();
    int n0, e0, t0, lat;
    n0 = done_n;
    e0 = err_n;
    align();
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 100.0);
    repeat (10) @(negedge CLK_I);
    checks++;
    if (done_n !== n0 + 1) begin
      errors++;
      $display("FAIL single_done_count: got %0d want %0d", done_n - n0, 1);
    end
    checks++;
    if (err_n !== e0) begin
      errors++;
      $display("FAIL single_no_ferr: got %0d want 0", err_n - e0);
    end
    checks++;
    if (DATA_O !== 8'hA5) begin
      errors++;
      $display("FAIL single_data: got %h want a5", DATA_O);
    end
    lat = (done_cyc.size() > 0) ? done_cyc[$] - t0 : -1;
    checks++;
    if (lat < 97 || lat > 99) begin
      errors++;
      $display("FAIL single_latency: got %0d want 98+-1", lat);
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL strobe_shape: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_back_to_back();
    int n0, gap;
    n0 = done_n;
    align();
    send_frame(8'h00, 1'b1, 100.0);
    send_frame(8'hFF, 1'b1, 100.0);
    repeat (10) @(negedge CLK_I);
    checks++;
    if (done_n !== n0 + 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d want 2", done_n - n0);
    end else begin
      checks++;
      if (done_data[$-1] !== 8'h00 || done_data[$] !== 8'hFF) begin
        errors++;
        $display("FAIL b2b_data: got %h,%h want 00,ff",
                 done_data[$-1], done_data[$]);
      end
      gap = done_cyc[$] - done_cyc[$-1];
      checks++;
      if (gap < 99 || gap > 101) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d want 100+-1", gap);
      end
    end
  endtask

  task automatic test_glitch();
    int n0, e0;
    n0 = done_n;
    e0 = err_n;
    align();
    RX_I = 1'b0;
    repeat (3) @(posedge CLK_I);
    #1;
    RX_I = 1'b1;
    repeat (7) @(negedge CLK_I);
    checks++;
    if (BUSY_O !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy: got %b want 0", BUSY_O);
    end
    repeat (20) @(negedge CLK_I);
    checks++;
    if (done_n !== n0 || err_n !== e0) begin
      errors++;
      $display("FAIL glitch_strobe: got %0d/%0d want 0/0",
               done_n - n0, err_n - e0);
    end
    checks++;
    if (DATA_O !== 8'hFF) begin
      errors++;
      $display("FAIL glitch_data: got %h want ff", DATA_O);
    end
  endtask

  task automatic test_frame_error();
    int n0, e0;
    n0 = done_n;
    e0 = err_n;
    align();
    send_frame(8'h3C, 1'b0, 100.0);
    #500;
    checks++;
    if (err_n !== e0 + 1) begin
      errors++;
      $display("FAIL ferr_count: got %0d want 1", err_n - e0);
    end
    checks++;
    if (done_n !== n0) begin
      errors++;
      $display("FAIL ferr_no_done: got %0d want 0", done_n - n0);
    end
    checks++;
    if (DATA_O !== 8'hFF) begin
      errors++;
      $display("FAIL ferr_data_hold: got %h want ff", DATA_O);
    end
    checks++;
    if (BUSY_O !== 1'b1) begin
      errors++;
      $display("FAIL break_busy: got %b want 1", BUSY_O);
    end
    RX_I = 1'b1;
    repeat (20) @(posedge CLK_I);
    checks++;
    if (BUSY_O !== 1'b0) begin
      errors++;
      $display("FAIL break_release: got %b want 0", BUSY_O);
    end
    align();
    send_frame(8'h12, 1'b1, 100.0);
    repeat (10) @(negedge CLK_I);
    checks++;
    if (DATA_O !== 8'h12 || done_n !== n0 + 1 || err_n !== e0 + 1) begin
      errors++;
      $display("FAIL after_ferr: got %h/%0d/%0d want 12/1/1",
               DATA_O, done_n - n0, err_n - e0);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d;
    int n0, e0;
    d  = 8'h55;
    n0 = done_n;
    e0 = err_n;
    align();
    RX_I = 1'b0;
    #100;
    for (int i = 0; i < 4; i++) begin
      RX_I = d[i];
      #100;
    end
    RX_I = d[4];
    #53;
    RST_I = 1'b1;
    #1;
    checks++;
    if ({DATA_O, RX_DONE_O, FRAME_ERR_O, BUSY_O} !== 11'h000) begin
      errors++;
      $display("FAIL mid_reset_clear: got %h/%b/%b/%b want 00/0/0/0",
               DATA_O, RX_DONE_O, FRAME_ERR_O, BUSY_O);
    end
    #20;
    RX_I = 1'b1;
    #3;
    RST_I = 1'b0;
    repeat (150) @(negedge CLK_I);
    checks++;
    if (done_n !== n0 || err_n !== e0) begin
      errors++;
      $display("FAIL mid_reset_no_strobe: got %0d/%0d want 0/0",
               done_n - n0, err_n - e0);
    end
    align();
    send_frame(8'h81, 1'b1, 100.0);
    repeat (10) @(negedge CLK_I);
    checks++;
    if (DATA_O !== 8'h81 || done_n !== n0 + 1) begin
      errors++;
      $display("FAIL after_reset_frame: got %h/%0d want 81/1",
               DATA_O, done_n - n0);
    end
  endtask

  task automatic test_tolerance();
    realtime bts[2];
    int n0;
    bts[0] = 97.0;
    bts[1] = 103.0;
    for (int k = 0; k < 2; k++) begin
      RST_I = 1'b1;
      #20;
      RST_I = 1'b0;
      repeat (20) @(posedge CLK_I);
      n0 = done_n;
      align();
      send_frame(8'hC3, 1'b1, bts[k]);
      repeat (10) @(negedge CLK_I);
      checks++;
      if (DATA_O !== 8'hC3 || done_n !== n0 + 1) begin
        errors++;
        $display("FAIL tolerance_%0d: got %h/%0d want c3/1",
                 k, DATA_O, done_n - n0);
      end
    end
  endtask

  initial begin
    RST_I = 1'b1;
    RX_I  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_mid_reset();
    test_tolerance();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL strobe_overlap_total: got %0d want 0", viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
